// File: rtl/aau_pkg.sv
// Shared definitions for the AAU byte-assembly unit: word/lane widths and
// the FSM state encoding, which doubles as the {hi_held, lo_held} flag pair.
package aau_pkg;

  localparam int AW = 16;
  localparam int BW = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    LOW   = 2'b01,
    HIGH  = 2'b10,
    FULL  = 2'b11
  } state_t;

endpackage

// File: rtl/aau.sv
// AAU: assembles a 16-bit word from two byte writes, with post-increment,
// consumer handshake and a sticky overflow flag.
module aau #(
  parameter int AW = aau_pkg::AW,
  parameter int BW = aau_pkg::BW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [BW-1:0] d,
  input  logic          wl,
  input  logic          wh,
  input  logic          ws,
  input  logic          inc,
  input  logic          ack,
  input  logic          clr,
  output logic [AW-1:0] q,
  output logic          vld,
  output logic          err
);

  import aau_pkg::*;

  state_t        state;
  state_t        next_state;
  state_t        after_ack;
  logic [BW-1:0] lo_byte;
  logic [BW-1:0] hi_byte;
  logic          load_lo;
  logic          load_hi;
  logic          set_err;
  logic          is_full;

  assign is_full   = (state == FULL);
  assign after_ack = (ack && is_full) ? EMPTY : state;

  // Writes act on the state as it stands after any ack in the same cycle.
  always_comb begin
    next_state = after_ack;
    load_lo    = 1'b0;
    load_hi    = 1'b0;
    set_err    = 1'b0;
    if (wl) begin
      load_lo    = 1'b1;
      next_state = state_t'({after_ack[1], 1'b1});
    end else if (wh) begin
      load_hi    = 1'b1;
      next_state = state_t'({1'b1, after_ack[0]});
    end else if (ws) begin
      case (after_ack)
        EMPTY: begin
          load_lo    = 1'b1;
          next_state = LOW;
        end
        LOW: begin
          load_hi    = 1'b1;
          next_state = FULL;
        end
        HIGH: begin
          load_lo    = 1'b1;
          next_state = FULL;
        end
        FULL: begin
          set_err    = 1'b1;
          next_state = FULL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else if (clr) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Increment first; a byte load later in this block overrides its lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_byte <= '0;
      hi_byte <= '0;
    end else if (clr) begin
      lo_byte <= '0;
      hi_byte <= '0;
    end else begin
      if (inc && is_full) begin
        {hi_byte, lo_byte} <= {hi_byte, lo_byte} + AW'(1);
      end
      if (load_lo) begin
        lo_byte <= d;
      end
      if (load_hi) begin
        hi_byte <= d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (clr) begin
      err <= 1'b0;
    end else if (set_err) begin
      err <= 1'b1;
    end
  end

  assign q   = {hi_byte, lo_byte};
  assign vld = (state == FULL);

endmodule

// File: tb/tb_aau.sv
// Self-checking bench for aau: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_aau;

  logic        clk;
  logic        rst;
  logic [7:0]  d;
  logic        wl, wh, ws, inc, ack, clr;
  logic [15:0] q;
  logic        vld;
  logic        err;

  int tests;
  int fails;

  // Behavioural model: the word plus which halves are currently held.
  logic [15:0] mq;
  bit          mlo;
  bit          mhi;
  bit          merr;

  aau dut (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .wl  (wl),
    .wh  (wh),
    .ws  (ws),
    .inc (inc),
    .ack (ack),
    .clr (clr),
    .q   (q),
    .vld (vld),
    .err (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    bit full;
    if (rst) begin
      mq = 16'h0000; mlo = 0; mhi = 0; merr = 0;
    end else if (clr) begin
      mq = 16'h0000; mlo = 0; mhi = 0; merr = 0;
    end else begin
      full = mlo && mhi;
      if (inc && full) mq = mq + 16'd1;
      if (ack && full) begin
        mlo = 0;
        mhi = 0;
      end
      if (wl) begin
        mq[7:0] = d; mlo = 1;
      end else if (wh) begin
        mq[15:8] = d; mhi = 1;
      end else if (ws) begin
        if (!mlo) begin
          mq[7:0] = d; mlo = 1;
        end else if (!mhi) begin
          mq[15:8] = d; mhi = 1;
        end else begin
          merr = 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model q",   q,           mq);
    checkOutput("model vld", {15'd0, vld}, {15'd0, (mlo && mhi)});
    checkOutput("model err", {15'd0, err}, {15'd0, merr});
  end

  task automatic applyStimulus(input logic [7:0] dv, input bit wlv, input bit whv,
                               input bit wsv, input bit incv, input bit ackv,
                               input bit clrv);
    d = dv; wl = wlv; wh = whv; ws = wsv; inc = incv; ack = ackv; clr = clrv;
    @(posedge clk);
    @(negedge clk);
    wl = 0; wh = 0; ws = 0; inc = 0; ack = 0; clr = 0;
  endtask

  task automatic checkLit(input string name, input logic [15:0] eq,
                          input bit ev, input bit ee);
    checkOutput({name, " q"},   q,            eq);
    checkOutput({name, " vld"}, {15'd0, vld}, {15'd0, ev});
    checkOutput({name, " err"}, {15'd0, err}, {15'd0, ee});
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 0; d = 8'h00; wl = 0; wh = 0; ws = 0; inc = 0; ack = 0; clr = 0;
    #1 rst = 1;
    // Strobes during reset must be ignored.
    ws = 1; d = 8'hAA;
    @(posedge clk);
    @(negedge clk);
    ws = 0;
    checkLit("reset", 16'h0000, 0, 0);
    rst = 0;
    @(negedge clk);

    applyStimulus(8'h0E, 0, 0, 1, 0, 0, 0);
    checkLit("seq1", 16'h000E, 0, 0);
    applyStimulus(8'h7A, 0, 0, 1, 0, 0, 0);
    checkLit("seq2", 16'h7A0E, 1, 0);
    applyStimulus(8'h00, 0, 0, 0, 0, 1, 0);
    checkLit("seq ack", 16'h7A0E, 0, 0);

    applyStimulus(8'h4E, 0, 1, 0, 0, 0, 0);
    applyStimulus(8'h20, 1, 0, 0, 0, 0, 0);
    checkLit("hl load", 16'h4E20, 1, 0);
    applyStimulus(8'h55, 0, 0, 1, 0, 0, 0);
    checkLit("overflow", 16'h4E20, 1, 1);
    applyStimulus(8'h00, 0, 0, 0, 0, 1, 0);
    checkLit("ack keeps err", 16'h4E20, 0, 1);
    applyStimulus(8'h00, 0, 0, 0, 0, 0, 1);
    checkLit("clr", 16'h0000, 0, 0);

    applyStimulus(8'hFF, 1, 0, 0, 0, 0, 0);
    applyStimulus(8'hFF, 0, 1, 0, 0, 0, 0);
    checkLit("ffff", 16'hFFFF, 1, 0);
    applyStimulus(8'h00, 0, 0, 0, 1, 0, 0);
    checkLit("inc wrap", 16'h0000, 1, 0);
    applyStimulus(8'h05, 1, 0, 0, 0, 0, 0);
    applyStimulus(8'h00, 0, 0, 0, 0, 1, 0);
    applyStimulus(8'h00, 0, 0, 0, 1, 0, 0);
    checkLit("inc ignored", 16'h0005, 0, 0);

    applyStimulus(8'h34, 1, 0, 0, 0, 0, 0);
    applyStimulus(8'h12, 0, 1, 0, 0, 0, 0);
    checkLit("1234", 16'h1234, 1, 0);
    applyStimulus(8'hAB, 0, 0, 1, 1, 1, 0);
    checkLit("inc ack ws", 16'h12AB, 0, 0);
    applyStimulus(8'h99, 0, 0, 1, 0, 0, 0);
    checkLit("after combo", 16'h99AB, 1, 0);

    applyStimulus(8'h00, 0, 0, 0, 0, 0, 1);
    applyStimulus(8'h3C, 1, 1, 1, 0, 0, 0);
    checkLit("priority", 16'h003C, 0, 0);

    applyStimulus(8'h00, 0, 0, 0, 0, 0, 1);
    applyStimulus(8'h11, 0, 0, 1, 0, 0, 0);
    checkLit("partial", 16'h0011, 0, 0);
    #2 rst = 1;
    #1 checkLit("async rst", 16'h0000, 0, 0);
    @(negedge clk);
    rst = 0;
    applyStimulus(8'h22, 0, 0, 1, 0, 0, 0);
    checkLit("post rst", 16'h0022, 0, 0);
    applyStimulus(8'h33, 0, 0, 1, 0, 0, 0);
    checkLit("post rst full", 16'h3322, 1, 0);

    for (int i = 0; i < 600; i++) begin
      applyStimulus(8'($urandom),
                    $urandom_range(0, 99) < 20,
                    $urandom_range(0, 99) < 20,
                    $urandom_range(0, 99) < 40,
                    $urandom_range(0, 99) < 35,
                    $urandom_range(0, 99) < 30,
                    $urandom_range(0, 99) < 4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
